// File: rtl/display_pkg.sv
// display_pkg: shared digit/frame geometry, blank code and sender state encoding.
package display_pkg;
  localparam int DIGIT_W = 5;
  localparam int NUM_DIGITS = 6;
  localparam int FRAME_W = DIGIT_W * NUM_DIGITS;
  localparam logic [DIGIT_W-1:0] BLANK = 5'h1F;
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;
  function automatic logic [DIGIT_W-1:0] pick(logic [FRAME_W-1:0] f, logic [2:0] i);
    return f[DIGIT_W*i +: DIGIT_W];
  endfunction
endpackage

// File: rtl/digit_sender_if.sv
// digit_sender_if: frame request handshake plus the digit/latch display bus.
interface digit_sender_if;
  import display_pkg::*;
  logic [FRAME_W-1:0] frame;
  logic start;
  logic busy;
  logic done;
  logic [DIGIT_W-1:0] digit;
  logic latch;
  modport master (output frame, start, input busy, done, digit, latch);
  modport slave (input frame, start, output busy, done, digit, latch);
endinterface

// File: rtl/digit_sender.sv
// digit_sender: snapshots a six-digit frame and shifts it out, position 5 first, one latch pulse per digit.
module digit_sender
  import display_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC = 2,
  parameter int HOLD_CYC = 2
) (
  input logic clk,
  input logic rst,
  digit_sender_if.slave bus
);
  localparam int MAX_CYC = SETUP_CYC > HIGH_CYC ? (SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC)
                                                : (HIGH_CYC > HOLD_CYC ? HIGH_CYC : HOLD_CYC);
  localparam int TW = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] T_HIGH = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0] T_HOLD = TW'(HOLD_CYC - 1);
  localparam logic [2:0] FIRST = 3'(NUM_DIGITS - 1);
  if (SETUP_CYC < 1 || HIGH_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
    $error("digit_sender phase lengths must be at least 1");
  end
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0] index, index_n;
  logic [FRAME_W-1:0] snap, snap_n;
  logic [DIGIT_W-1:0] digit, digit_n;
  logic latch, latch_n;
  logic last;
  logic accept;
  // The final HOLD cycle doubles as the done cycle, so a new frame can start with no gap.
  assign last = state == HOLD && timer == '0 && index == '0;
  assign accept = (state == IDLE || last) && bus.start;
  always_comb begin
    state_n = state;
    timer_n = timer;
    index_n = index;
    snap_n = snap;
    digit_n = digit;
    latch_n = latch;
    if (accept) begin
      state_n = SETUP;
      timer_n = T_SETUP;
      index_n = FIRST;
      snap_n = bus.frame;
      digit_n = pick(bus.frame, FIRST);
      latch_n = 1'b0;
    end else if (timer != '0) begin
      timer_n = timer - 1'b1;
    end else begin
      unique case (state)
        SETUP: begin
          state_n = HIGH;
          timer_n = T_HIGH;
          latch_n = 1'b1;
        end
        HIGH: begin
          state_n = HOLD;
          timer_n = T_HOLD;
          latch_n = 1'b0;
        end
        HOLD: begin
          if (index == '0) begin
            state_n = IDLE;
          end else begin
            state_n = SETUP;
            timer_n = T_SETUP;
            index_n = index - 3'd1;
            digit_n = pick(snap, index - 3'd1);
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      index <= '0;
      snap <= '0;
      digit <= '0;
      latch <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      index <= index_n;
      snap <= snap_n;
      digit <= digit_n;
      latch <= latch_n;
    end
  end
  assign bus.busy = state != IDLE && !last;
  assign bus.done = last;
  assign bus.digit = digit;
  assign bus.latch = latch;
endmodule

// File: tb/tb_digit_sender.sv
// tb_digit_sender: per-cycle schedule model plus receiver model for default and 1/1/1 timing.
module tb_digit_sender;
  import display_pkg::*;
  localparam logic [29:0] F1 = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [29:0] F2 = {5'd12, 5'd11, 5'd10, 5'd9, 5'd8, 5'd7};
  localparam logic [29:0] F3 = {5'd22, 5'd21, 5'd20, 5'd19, 5'd18, 5'd17};
  localparam logic [29:0] F4 = {5'd9, 5'd5, 5'd9, 5'h1F, 5'd0, 5'd0};
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  digit_sender_if ia();
  digit_sender_if ib();
  digit_sender dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  digit_sender #(.SETUP_CYC(1), .HIGH_CYC(1), .HOLD_CYC(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  logic st[2];
  logic [29:0] fr[2];
  logic [4:0] dg[2];
  logic lt[2], bz[2], dn[2];
  assign ia.start = st[0];
  assign ia.frame = fr[0];
  assign ib.start = st[1];
  assign ib.frame = fr[1];
  assign dg[0] = ia.digit;
  assign dg[1] = ib.digit;
  assign lt[0] = ia.latch;
  assign lt[1] = ib.latch;
  assign bz[0] = ia.busy;
  assign bz[1] = ib.busy;
  assign dn[0] = ia.done;
  assign dn[1] = ib.done;

  function automatic int phase(int i);
    return i == 0 ? 2 : 1;
  endfunction
  function automatic int flen(int i);
    return 6 * 3 * phase(i);
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Model: cycle k (1..L) of an accepted frame; k==L is the done cycle.
  logic act[2];
  int k[2];
  logic [29:0] mf[2];
  logic [4:0] mlast[2];
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] <= 1'b0;
        k[i] <= 0;
        mlast[i] <= '0;
      end else if ((!act[i] || k[i] == flen(i)) && st[i]) begin
        act[i] <= 1'b1;
        k[i] <= 1;
        mf[i] <= fr[i];
      end else if (act[i] && k[i] == flen(i)) begin
        act[i] <= 1'b0;
        mlast[i] <= mf[i][4:0];
      end else if (act[i]) begin
        k[i] <= k[i] + 1;
      end
    end
  end

  function automatic logic [7:0] exp_out(int i);
    int p, j, r;
    logic [4:0] d;
    p = 3 * phase(i);
    if (!act[i]) return {3'b000, mlast[i]};
    j = (k[i] - 1) / p;
    r = (k[i] - 1) % p;
    d = mf[i][5*(5-j) +: 5];
    return {k[i] < flen(i), k[i] == flen(i), r >= phase(i) && r < 2 * phase(i), d};
  endfunction

  logic plt[2];
  int rises[2], falls[2];
  logic [29:0] recv[2];
  always begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) check($sformatf("cycle_dut%0d", i), {24'd0, bz[i], dn[i], lt[i], dg[i]}, {24'd0, exp_out(i)});
      if (plt[i] === 1'b1 && lt[i] === 1'b0) begin
        recv[i] = {recv[i][24:0], dg[i]};
        falls[i]++;
      end
      if (plt[i] === 1'b0 && lt[i] === 1'b1) rises[i]++;
      plt[i] = lt[i];
    end
  end

  task automatic send(input int i, input logic [29:0] f, input bit noise, input int exp_len);
    int n;
    @(posedge clk);
    #1;
    fr[i] = f;
    st[i] = 1'b1;
    rises[i] = 0;
    falls[i] = 0;
    @(posedge clk);
    #1;
    st[i] = 1'b0;
    if (noise) fr[i] = {6{5'd9}};
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (noise && (n == 5 || n == 20)) st[i] = 1'b1;
      if (noise && (n == 6 || n == 21)) st[i] = 1'b0;
      if (dn[i] === 1'b1) break;
    end
    check($sformatf("done_latency_dut%0d", i), n, exp_len);
    check($sformatf("busy_at_done_dut%0d", i), bz[i], 0);
    @(negedge clk);
    check($sformatf("latch_rises_dut%0d", i), rises[i], 6);
    check($sformatf("latch_falls_dut%0d", i), falls[i], 6);
    check($sformatf("receiver_dut%0d", i), recv[i], f);
    check($sformatf("idle_digit_dut%0d", i), dg[i], f[4:0]);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    st = '{1'b0, 1'b0};
    fr = '{30'd0, 30'd0};
    plt = '{1'b0, 1'b0};
    rises = '{0, 0};
    falls = '{0, 0};
    recv = '{30'd0, 30'd0};
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_outputs_a", {bz[0], dn[0], lt[0], dg[0]}, 0);
    check("reset_outputs_b", {bz[1], dn[1], lt[1], dg[1]}, 0);
    @(negedge clk);
    rst = 1'b0;
    send(0, F1, 1'b0, 36);
    send(1, F1, 1'b0, 18);
    // Back-to-back: start held high; second frame takes the value present in the done cycle.
    @(posedge clk);
    #1;
    fr[0] = F2;
    st[0] = 1'b1;
    rises[0] = 0;
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (dn[0] === 1'b1) break;
    end
    check("b2b_first_done", n, 36);
    check("b2b_first_recv", recv[0], F2);
    fr[0] = F3;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (dn[0] === 1'b1) break;
    end
    st[0] = 1'b0;
    check("b2b_second_done", n, 36);
    @(negedge clk);
    check("b2b_second_recv", recv[0], F3);
    check("b2b_rises", rises[0], 12);
    // Reset while latch is high during the third digit.
    @(posedge clk);
    #1;
    fr[0] = F1;
    st[0] = 1'b1;
    rises[0] = 0;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (rises[0] == 3 && lt[0] === 1'b1) break;
    end
    check("reset_reach_digit3", n < 100, 1);
    rst = 1'b1;
    #1;
    check("midreset_latch", lt[0], 0);
    check("midreset_busy", bz[0], 0);
    check("midreset_digit", dg[0], 0);
    check("midreset_done", dn[0], 0);
    @(negedge clk);
    rst = 1'b0;
    send(0, F4, 1'b0, 36);
    send(0, F1, 1'b1, 36);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
